rom_dl_arbiter: RTL
===================

Name: rom_dl_arbiter

Overview:
- Sequences the MiSTer ROM download into the shared single-port program ROM/RAM.
- Arbitrates that memory port between the download stream and the CPU read requester.
- Owns the core reset: the game core is held in reset until a download completes and a settle delay expires.
- Sits between hps_io (ioctl_*) and the berzerk/Frenzy core memory.

Parameters:
- ROM_SIZE, 32'h10000, number of loadable bytes; download addresses >= ROM_SIZE are dropped.
- SETTLE_CYCLES, 16, clk_sys cycles core_reset stays high after download end (range 1..255).

Ports:
- clk_sys  in  1  system clock (40 MHz).
- reset  in  1  asynchronous, active-high reset.
- dn_download  in  1  download in progress (ioctl_download).
- dn_addr  in  16  download byte address.
- dn_data  in  8  download byte.
- dn_wr  in  1  one-cycle download write strobe.
- cpu_rd  in  1  CPU read request; held high until cpu_ack.
- cpu_addr  in  16  CPU read address; stable while cpu_rd is high.
- cpu_di  out  8  CPU read data; valid in the cpu_ack cycle and held until the next ack.
- cpu_ack  out  1  one-cycle read-complete pulse.
- mem_addr  out  16  memory address (registered).
- mem_din  out  8  memory write data (registered).
- mem_we  out  1  memory write enable (registered).
- mem_dout  in  8  memory read data; one-cycle latency after mem_addr.
- core_reset  out  1  reset to the game core.
- dl_done  out  1  high once at least one download has completed since reset.
- dl_count  out  17  bytes accepted in the current or last download.

Behaviour:
- Reset (async): state=IDLE; core_reset=1; mem_we=0; mem_addr=0; mem_din=0; cpu_ack=0; cpu_di=0; dl_done=0; dl_count=0; settle counter=0.
- FSM states and transitions:
  - IDLE: core_reset=1, CPU reads not serviced. dn_download=1 -> LOAD.
  - LOAD: core_reset=1, dl_count cleared on entry. dn_download=0 -> SETTLE, settle counter loaded with SETTLE_CYCLES.
  - SETTLE: core_reset=1, counter decrements each cycle. Reaching 0 -> RUN, dl_done=1. dn_download=1 -> LOAD (counter abandoned).
  - RUN: core_reset=0. dn_download=1 -> LOAD; core_reset rises in the same cycle as the transition (registered, visible next edge).
- Download write:
  - dn_wr=1 in LOAD with dn_addr < ROM_SIZE: next cycle mem_we=1, mem_addr=dn_addr, mem_din=dn_data; dl_count increments.
  - Otherwise the strobe is ignored. mem_we is a single-cycle pulse.
  - Back-to-back dn_wr on consecutive cycles is supported: one write per cycle, no loss.
  - dn_wr outside LOAD (incl. the entry cycle of IDLE->LOAD) is treated as in LOAD if dn_download=1 that cycle.
- CPU read (RUN only):
  - Cycle N: cpu_rd=1 sampled with no read in flight.
  - N+1: mem_addr=cpu_addr.
  - N+2: mem_dout captured to cpu_di; cpu_ack=1.
  - Next request is accepted no earlier than N+3.
  - cpu_rd low at N is ignored.
  - Download has absolute priority: leaving RUN mid-read aborts it, with no cpu_ack.
  - Reads pending in IDLE/LOAD/SETTLE stall (no ack) until RUN.
- mem_we is never high in RUN. mem_addr holds its last value when idle.
- dl_count saturates at ROM_SIZE (never wraps).
- Reset mid-download: everything returns to IDLE. The partial load is not considered done.

Optional Feature:
- Macro DL_CHECKSUM_EN.
- Defined: extra output dl_sum [7:0], the modulo-256 sum of every accepted download byte; cleared on LOAD entry, reset to 0; updates the cycle mem_we is asserted.
- Undefined: the port is absent and the logic is not generated. All other behaviour is identical.

Test Plan:
- Reset release with no download -> core_reset stays 1, dl_done=0, and cpu_rd=1 for 100 cycles gives no cpu_ack.
- Download of 4 bytes 0x11,0x22,0x33,0x44 at 0x0000-0x0003 on consecutive cycles, then dn_download=0 -> four mem_we pulses with matching addr/data; dl_count=4; core_reset falls exactly SETTLE_CYCLES+1 cycles after dn_download falls; dl_done=1.
- dn_wr at 0xFFFF with ROM_SIZE=16'hC000 -> no mem_we, dl_count unchanged.
- In RUN, cpu_rd with cpu_addr=0x1234 and memory returning 0xA5 -> mem_addr=0x1234 at N+1; cpu_ack and cpu_di=0xA5 at N+2; a held cpu_rd gives its next ack at N+5.
- dn_download asserted at N+1 of a CPU read -> no cpu_ack, core_reset=1 next cycle, dl_count=0.
- With DL_CHECKSUM_EN: bytes 0xFF,0x02 -> dl_sum=0x01; a second download restarts from 0.

Source files
------------

// File: rtl/rom_dl_arbiter.sv
// rom_dl_arbiter: sequences the MiSTer ROM download into the shared program
// memory and shares that single port with the CPU read requester. The game
// core stays in reset until a download has finished and a settle delay has
// run out.
//
// Optional build macro: DL_CHECKSUM_EN adds the dl_sum output, which is the
// modulo-256 sum of the bytes accepted in the current or last download.
module rom_dl_arbiter #(
  parameter logic [31:0] ROM_SIZE      = 32'h10000,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dn_download,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        dn_wr,
  input  logic        cpu_rd,
  input  logic [15:0] cpu_addr,
  output logic [7:0]  cpu_di,
  output logic        cpu_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout,
  output logic        core_reset,
  output logic        dl_done,
`ifdef DL_CHECKSUM_EN
  output logic [7:0]  dl_sum,
`endif
  output logic [16:0] dl_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rdPhase_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

  state_t      state_q;
  logic [7:0]  settleCnt_q;
  logic        coreReset_q;
  logic        dlDone_q;

  rdPhase_t    rdPhase_q,   rdPhase_d;
  logic        cpuAck_q,    cpuAck_d;
  logic [7:0]  cpuDiHold_q, cpuDiHold_d;
  logic [15:0] memAddr_q,   memAddr_d;
  logic [7:0]  memDin_q,    memDin_d;
  logic        memWe_q,     memWe_d;
  logic [16:0] dlCount_q,   dlCount_d;

  logic        loadEntry;
  logic        inRange;
  logic        wrAccept;
  logic        cpuServe;
  logic [16:0] countBase;

  // Decode the shared conditions used by both the FSM and the datapath.
  // Any raised dn_download outside LOAD is the entry into LOAD. A strobe is
  // already honoured in that entry cycle, and also in the last LOAD cycle
  // when dn_download has just dropped. The CPU is only serviced in RUN when
  // no download is starting, which gives the download absolute priority.
  always_comb begin
    loadEntry = dn_download && (state_q != LOAD);
    inRange   = ({16'd0, dn_addr} < ROM_SIZE);
    wrAccept  = dn_wr && inRange && (dn_download || (state_q == LOAD));
    cpuServe  = (state_q == RUN) && !dn_download;
  end

  // Control FSM. It owns core_reset, the settle counter and the sticky
  // dl_done flag. These outputs are registered, so the release of
  // core_reset is seen one edge after the decision is made.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      settleCnt_q <= 8'd0;
      coreReset_q <= 1'b1;
      dlDone_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          coreReset_q <= 1'b1;
          if (dn_download) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          coreReset_q <= 1'b1;
          if (!dn_download) begin
            state_q     <= SETTLE;
            settleCnt_q <= SETTLE_INIT;
          end
        end
        SETTLE: begin
          if (dn_download) begin
            state_q     <= LOAD;
            settleCnt_q <= 8'd0;
            coreReset_q <= 1'b1;
          end else begin
            settleCnt_q <= settleCnt_q - 8'd1;
            if (settleCnt_q <= 8'd1) begin
              state_q     <= RUN;
              coreReset_q <= 1'b0;
              dlDone_q    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (dn_download) begin
            state_q     <= LOAD;
            coreReset_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          coreReset_q <= 1'b1;
        end
      endcase
    end
  end

  // Next-state logic for the memory port, the CPU read sequencer and the
  // byte counter. A write and a CPU read can never both want the port in
  // the same cycle, because a write needs a download and a read excludes it.
  // mem_addr keeps its last value whenever the port is idle.
  always_comb begin
    memWe_d     = wrAccept;
    memAddr_d   = memAddr_q;
    memDin_d    = memDin_q;
    rdPhase_d   = rdPhase_q;
    cpuAck_d    = 1'b0;
    cpuDiHold_d = cpuAck_q ? mem_dout : cpuDiHold_q;
    countBase   = loadEntry ? 17'd0 : dlCount_q;
    dlCount_d   = countBase;

    if (wrAccept) begin
      memAddr_d = dn_addr;
      memDin_d  = dn_data;
      if ({15'd0, countBase} < ROM_SIZE) begin
        dlCount_d = countBase + 17'd1;
      end
    end

    if (!cpuServe) begin
      rdPhase_d = RD_IDLE;
    end else begin
      case (rdPhase_q)
        RD_IDLE: begin
          if (cpu_rd) begin
            rdPhase_d = RD_ADDR;
            memAddr_d = cpu_addr;
          end
        end
        RD_ADDR: begin
          rdPhase_d = RD_DATA;
          cpuAck_d  = 1'b1;
        end
        RD_DATA: begin
          rdPhase_d = RD_IDLE;
        end
        default: begin
          rdPhase_d = RD_IDLE;
        end
      endcase
    end
  end

  // Datapath registers for the memory port, the CPU handshake and the counter.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rdPhase_q   <= RD_IDLE;
      cpuAck_q    <= 1'b0;
      cpuDiHold_q <= 8'd0;
      memAddr_q   <= 16'd0;
      memDin_q    <= 8'd0;
      memWe_q     <= 1'b0;
      dlCount_q   <= 17'd0;
    end else begin
      rdPhase_q   <= rdPhase_d;
      cpuAck_q    <= cpuAck_d;
      cpuDiHold_q <= cpuDiHold_d;
      memAddr_q   <= memAddr_d;
      memDin_q    <= memDin_d;
      memWe_q     <= memWe_d;
      dlCount_q   <= dlCount_d;
    end
  end

`ifdef DL_CHECKSUM_EN
  logic [7:0] dlSum_q, dlSum_d;

  // The running byte sum restarts on LOAD entry. It advances together with
  // the registered write, so it changes in the same cycle that mem_we is high.
  always_comb begin
    dlSum_d = (loadEntry ? 8'd0 : dlSum_q) + (wrAccept ? dn_data : 8'd0);
  end

  // Register holding the byte sum.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dlSum_q <= 8'd0;
    end else begin
      dlSum_q <= dlSum_d;
    end
  end

  assign dl_sum = dlSum_q;
`endif

  // The memory returns data one cycle after the address. In the ack cycle
  // cpu_di shows mem_dout directly; after that it shows the captured copy
  // until the next acknowledge.
  assign cpu_di     = cpuAck_q ? mem_dout : cpuDiHold_q;
  assign cpu_ack    = cpuAck_q;
  assign mem_addr   = memAddr_q;
  assign mem_din    = memDin_q;
  assign mem_we     = memWe_q;
  assign core_reset = coreReset_q;
  assign dl_done    = dlDone_q;
  assign dl_count   = dlCount_q;

endmodule
